// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle for the round-robin arbiter: per-port request streams in,
// one merged registered stream out.
interface stream_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic [NUM_PORTS-1:0]            s_valid;
  logic [NUM_PORTS-1:0]            s_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0]            s_last;
  logic                            m_valid;
  logic                            m_ready;
  logic [DATA_WIDTH-1:0]           m_data;
  logic                            m_last;
  logic [ID_WIDTH-1:0]             m_id;

  // Arbiter side: consumes the request streams and drives the merged stream.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_id
  );

  // Environment side: the requesters plus the downstream consumer.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_id
  );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_PORTS valid/ready streams into
// one registered output stage. A granted port owns the output until its last
// beat (or for one beat when LOCK_ON_LAST=0); the next search starts just
// after the port that finished, so a busy port cannot starve the others.
module stream_rr_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int LOCK_ON_LAST = 1,
  parameter int ID_WIDTH     = 2
) (
  input  logic                clk,
  input  logic                rst,
  stream_rr_arbiter_if.slave  bus,
  output logic                busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [ID_WIDTH:0]   PORTS_EXT = (ID_WIDTH+1)'(NUM_PORTS);
  localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic [ID_WIDTH-1:0]     m_id_q, m_id_d;

  logic                    pipe_ready;
  logic                    accept;
  logic [NUM_PORTS-1:0]    s_ready;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    req_found;
  logic [ID_WIDTH-1:0]     req_pick;
  logic [ID_WIDTH:0]       scan_idx;

  // Select the granted port's valid/last/data for the output register.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = bus.s_valid[i];
        sel_last  = bus.s_last[i];
        sel_data  = bus.s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Find the first requesting port starting at ptr and wrapping around.
  always_comb begin
    req_found = 1'b0;
    req_pick  = ptr_q;
    scan_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
      if (scan_idx >= PORTS_EXT) begin
        scan_idx = scan_idx - PORTS_EXT;
      end
      if (!req_found && bus.s_valid[scan_idx[ID_WIDTH-1:0]]) begin
        req_found = 1'b1;
        req_pick  = scan_idx[ID_WIDTH-1:0];
      end
    end
  end

  // Next-state, grant/pointer update and output-register load logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_id_d     = m_id_q;
    s_ready    = '0;
    accept     = 1'b0;
    pipe_ready = bus.m_ready || !m_valid_q;

    case (state_q)
      IDLE: begin
        if (req_found) begin
          grant_d = req_pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        s_ready[grant_q] = pipe_ready;
        accept           = sel_valid && pipe_ready;
        if (accept && (sel_last || (LOCK_ON_LAST == 0))) begin
          state_d = IDLE;
          ptr_d   = (grant_q == LAST_PORT) ? '0 : grant_q + ID_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_last_d  = sel_last;
      m_id_d    = grant_q;
    end else if (pipe_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_id_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_id_q    <= m_id_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_id    = m_id_q;
  assign busy        = (state_q == GRANT);

endmodule
